// File: rtl/ntt_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : ntt_coeff_loader
// Purpose  : Collects a serial valid/ready stream of W-bit coefficients into
//            an N-entry parallel array for the NTT core, and sequences the
//            core's start/done handshake (FILL -> RUN -> RELEASE -> FILL).
// Options  : NTT_LOADER_REDUCE_EN - when defined, each coefficient is reduced
//            into [0, Q) by one conditional subtract before it is stored.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_coeff_loader #(
    parameter int N = 256,
    parameter int W = 12,
    parameter int Q = 3329
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [W-1:0]         s_data_i,
    input  logic                 s_last_i,
    input  logic                 flush_i,
    output logic                 ntt_start_o,
    input  logic                 ntt_done_i,
    output logic [W-1:0]         coeff_o [0:N-1],
    output logic [$clog2(N):0]   fill_cnt_o,
    output logic                 frame_err_o,
    output logic                 vec_done_o
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Elaboration-time sanity checks on the parameter set.
    if ((N & (N - 1)) != 0 || N < 2) begin : g_bad_n
        $error("ntt_coeff_loader: N must be a power of two >= 2");
    end
    if (Q <= 0 || Q >= (1 << W) || (2 * Q) <= ((1 << W) - 1)) begin : g_bad_q
        $error("ntt_coeff_loader: Q must satisfy 2^W-1 < 2Q and Q < 2^W");
    end

    logic [1:0]    state;
    logic [CW-1:0] fill_cnt;
    logic          frame_err;
    logic          handshake;
    logic          at_end;
    logic [W-1:0]  wr_data;

    assign s_ready_o   = (state == ST_FILL);
    assign ntt_start_o = (state == ST_RUN);
    assign vec_done_o  = (state == ST_RELEASE);
    assign fill_cnt_o  = fill_cnt;
    assign frame_err_o = frame_err;

    assign handshake = s_valid_i && (state == ST_FILL);
    assign at_end    = (fill_cnt == CW'(N - 1));

`ifdef NTT_LOADER_REDUCE_EN
    // Single conditional subtract suffices because the input is below 2Q.
    localparam logic [W-1:0] QW = W'(Q);
    assign wr_data = (s_data_i >= QW) ? (s_data_i - QW) : s_data_i;
`else
    assign wr_data = s_data_i;
`endif

    // Control: state, fill counter and the framing-error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_FILL;
            fill_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (flush_i) begin
                state    <= ST_FILL;
                fill_cnt <= '0;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (handshake) begin
                            if (s_last_i || at_end) begin
                                // last without end (early) or end without last
                                // (missing) is a framing error; both enter RUN
                                state     <= ST_RUN;
                                fill_cnt  <= CW'(N);
                                frame_err <= s_last_i ^ at_end;
                            end else begin
                                fill_cnt <= fill_cnt + 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (ntt_done_i) begin
                            state    <= ST_RELEASE;
                            fill_cnt <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        state <= ST_FILL;
                    end
                    default: begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Coefficient array: write the accepted beat, zero-pad the tail on early last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                coeff_o[i] <= '0;
            end
        end else if (handshake && !flush_i) begin
            for (int i = 0; i < N; i++) begin
                if (i == int'(fill_cnt)) begin
                    coeff_o[i] <= wr_data;
                end else if (s_last_i && (i > int'(fill_cnt))) begin
                    coeff_o[i] <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_coeff_loader
// Purpose  : Directed self-checking bench for ntt_coeff_loader. Honours
//            NTT_LOADER_REDUCE_EN for the reduction expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_coeff_loader;

    localparam int N = 256;
    localparam int W = 12;
    localparam int BOUND = 3000;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic          flush;
    logic          ntt_start;
    logic          ntt_done;
    logic [W-1:0]  coeff [0:N-1];
    logic [8:0]    fill_cnt;
    logic          frame_err;
    logic          vec_done;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int done_pulses = 0;
    int base_err;
    int base_done;
    logic [W-1:0] tbl [0:3];
    logic [W-1:0] exp_red [0:3];

    ntt_coeff_loader #(.N(N), .W(W), .Q(3329)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .flush_i     (flush),
        .ntt_start_o (ntt_start),
        .ntt_done_i  (ntt_done),
        .coeff_o     (coeff),
        .fill_cnt_o  (fill_cnt),
        .frame_err_o (frame_err),
        .vec_done_o  (vec_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors: each one-cycle pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (vec_done === 1'b1) done_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat (valid stays high afterwards) and return just after the
    // edge on which it was accepted.
    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < BOUND) begin
            tick();
            t++;
        end
        if (!s_ready) check("ready_timeout", 0, 1);
        tick();
    endtask

    task automatic send_vec(input int base, input int step, input int len, input int last_at);
        for (int k = 0; k < len; k++) begin
            send_beat(W'(base + k * step), (k == last_at));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // NTT core model: done raised in the 20th start-high cycle.
    task automatic ntt_model(input string tag);
        int t = 0;
        int hi = 0;
        while (!ntt_start && t < BOUND) begin
            tick();
            t++;
        end
        check({tag, "_start"}, ntt_start, 1);
        check({tag, "_cnt_run"}, fill_cnt, N);
        for (int c = 1; c <= 20; c++) begin
            if (ntt_start) hi++;
            if (c == 20) ntt_done = 1'b1;
            tick();
        end
        ntt_done = 1'b0;
        check({tag, "_start_cycles"}, hi, 20);
        check({tag, "_rel_start"}, ntt_start, 0);
        check({tag, "_rel_vdone"}, vec_done, 1);
        check({tag, "_rel_ready"}, s_ready, 0);
        check({tag, "_rel_cnt"}, fill_cnt, 0);
        tick();
        check({tag, "_fill_ready"}, s_ready, 1);
        check({tag, "_fill_vdone"}, vec_done, 0);
    endtask

    task automatic check_arith(input string tag, input int base, input int step, input int len);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (i < len) begin
                if (coeff[i] !== W'(base + i * step)) bad++;
            end else if (coeff[i] !== '0) begin
                bad++;
            end
        end
        check(tag, bad, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        flush    = 1'b0;
        ntt_done = 1'b0;
        tbl[0] = 12'd3328; tbl[1] = 12'd3329; tbl[2] = 12'd4095; tbl[3] = 12'd0;
`ifdef NTT_LOADER_REDUCE_EN
        exp_red[0] = 12'd3328; exp_red[1] = 12'd0; exp_red[2] = 12'd766; exp_red[3] = 12'd0;
`else
        exp_red[0] = 12'd3328; exp_red[1] = 12'd3329; exp_red[2] = 12'd4095; exp_red[3] = 12'd0;
`endif
        #23;
        check("rst_ready", s_ready, 1);
        check("rst_start", ntt_start, 0);
        check("rst_cnt", fill_cnt, 0);
        check("rst_err", frame_err, 0);
        check("rst_vdone", vec_done, 0);
        check_arith("rst_coeff", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full vector 0..255, last on beat 255.
        base_err = err_pulses;
        send_beat(W'(0), 1'b0);
        check("stream_cnt1", fill_cnt, 1);
        s_valid = 1'b0;
        send_vec(1, 1, 254, -1);
        check("stream_cnt255", fill_cnt, 255);
        send_beat(W'(255), 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("stream_start_lat", ntt_start, 1);
        check("stream_ready_run", s_ready, 0);
        ntt_model("stream");
        check_arith("stream_coeff", 0, 1, N);
        check("stream_no_err", err_pulses - base_err, 0);

        // Early last on beat 9: tail zero-padded over the previous contents.
        base_err = err_pulses;
        send_vec(1000, 1, 10, 9);
        check("early_err_now", frame_err, 1);
        check("early_run", ntt_start, 1);
        check_arith("early_coeff", 1000, 1, 10);
        ntt_model("early");
        check("early_err_once", err_pulses - base_err, 1);

        // Missing last: 256 beats, last never asserted.
        base_err = err_pulses;
        send_vec(0, 2, N, -1);
        check("miss_err_now", frame_err, 1);
        check("miss_run", ntt_start, 1);
        ntt_model("miss");
        check("miss_err_once", err_pulses - base_err, 1);
        check_arith("miss_coeff", 0, 2, N);

        // Flush at count 100 while a beat is offered: flush wins.
        base_err  = err_pulses;
        base_done = done_pulses;
        send_vec(7, 1, 100, -1);
        check("flushf_cnt100", fill_cnt, 100);
        s_valid = 1'b1;
        s_data  = 12'd555;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flushf_cnt", fill_cnt, 0);
        check("flushf_ready", s_ready, 1);
        check("flushf_c99", coeff[99], 106);
        check("flushf_c100", coeff[100], 200);
        tick();
        check("flushf_pulses", (err_pulses - base_err) + (done_pulses - base_done), 0);

        // Flush during RUN aborts the transform.
        base_done = done_pulses;
        send_vec(0, 1, N, N - 1);
        check("flushr_run", ntt_start, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flushr_start", ntt_start, 0);
        check("flushr_ready", s_ready, 1);
        check("flushr_cnt", fill_cnt, 0);
        tick();
        check("flushr_vdone", done_pulses - base_done, 0);

        // Reduction path, then early-last padding.
        for (int k = 0; k < 4; k++) begin
            send_beat(tbl[k], (k == 3));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("red_err", frame_err, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("red_c%0d", k), coeff[k], exp_red[k]);
        end
        check("red_c4", coeff[4], 0);
        check("red_c255", coeff[255], 0);
        ntt_model("red");

        // Asynchronous reset in the middle of RUN.
        send_vec(50, 1, N, N - 1);
        check("arst_pre_run", ntt_start, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_start", ntt_start, 0);
        check("arst_ready", s_ready, 1);
        check("arst_cnt", fill_cnt, 0);
        check_arith("arst_coeff", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back vectors with valid held high across RUN/RELEASE.
        base_done = done_pulses;
        fork
            begin
                send_vec(300, 1, N, N - 1);
                s_valid = 1'b1;
                send_vec(2000, 3, N, N - 1);
            end
            begin
                ntt_model("b2b_a");
                ntt_model("b2b_b");
            end
        join
        check_arith("b2b_coeff", 2000, 3, N);
        check("b2b_vdone", done_pulses - base_done, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
